// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction-cache controller. It owns the tag and valid
// arrays, sequences lookup, a 4-beat in-order line refill and the write into
// the external data array, and returns the requested word to the CPU.
module icache_refill_ctrl #(
  parameter  int CACHE_LINE = 128,
  parameter  int CACHE_SIZE = 8192,
  localparam int NLINES     = CACHE_SIZE * 8 / CACHE_LINE,
  localparam int IDX_W      = $clog2(NLINES),
  localparam int TAG_W      = 32 - IDX_W - 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [31:0]           cpu_addr,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_rdata,
  input  logic                  flush,
  output logic                  busy,
  output logic [IDX_W-1:0]      line_idx,
  input  logic [CACHE_LINE-1:0] line_rdata,
  output logic                  line_we,
  output logic [CACHE_LINE-1:0] line_wdata,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_REFILL,
    S_WRITE,
    S_RESPOND,
    S_FLUSH
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [31:2]       r_addr;        // latched word address of the request
  logic [1:0]        r_beat;        // next refill beat to accept
  logic [3:0][31:0]  r_buf;         // refill line buffer, word k = beat k
  logic [NLINES-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag_ram [NLINES];
  logic              r_flush_pend;  // flush seen while a transaction was open

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_off;
  logic              w_hit;
  logic              w_accept;

  // Byte-lane bits of the fetch address play no part in a word fetch.
  logic              w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^cpu_addr[1:0];

  assign w_tag    = r_addr[31:IDX_W+4];
  assign w_idx    = r_addr[IDX_W+3:4];
  assign w_off    = r_addr[3:2];
  assign w_hit    = r_valid[w_idx] && (r_tag_ram[w_idx] == w_tag);
  assign w_accept = (r_state == S_IDLE) && !flush && !r_flush_pend && cpu_req;
  assign line_idx = w_idx;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output and the next state get a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    w_next     = r_state;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    line_we    = 1'b0;
    line_wdata = '0;
    busy       = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        // A flush, new or pending, wins over a waiting fetch.
        if (flush || r_flush_pend) w_next = S_FLUSH;
        else if (cpu_req)          w_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = line_rdata[{w_off, 5'b00000} +: 32];
          w_next    = S_IDLE;
        end else begin
          w_next = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, r_beat, 2'b00};
        if (mem_ready && (r_beat == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        line_we    = 1'b1;
        line_wdata = r_buf;
        w_next     = S_RESPOND;
      end
      S_RESPOND: begin
        cpu_ready = 1'b1;
        cpu_rdata = r_buf[w_off];
        w_next    = S_IDLE;
      end
      S_FLUSH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, beat counter, line buffer, valid bits and flush flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_beat       <= '0;
      r_buf        <= '0;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_accept) r_addr <= cpu_addr[31:2];

      if (r_state == S_COMPARE) r_beat <= '0;

      if ((r_state == S_REFILL) && mem_ready) begin
        r_buf[r_beat] <= mem_rdata;
        r_beat        <= r_beat + 2'd1;
      end

      if (r_state == S_WRITE) r_valid[w_idx] <= 1'b1;

      // A flush that arrives mid-transaction is deferred to the next IDLE,
      // so a line filled in the same cycle is invalidated as well.
      if (r_state == S_FLUSH) begin
        r_valid      <= '0;
        r_flush_pend <= 1'b0;
      end else if (flush && (r_state != S_IDLE)) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  // Tag array write on line fill.
  always_ff @(posedge clk) begin
    // NOTE: the tag array is not reset; the valid bits alone qualify its
    // contents, which lets it map onto plain RAM.
    if (r_state == S_WRITE) r_tag_ram[w_idx] <= w_tag;
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed scenarios followed by
// randomized fetches, checked against a tag/valid model of the cache and an
// arithmetic memory model (data = address - 0xA00).
module tb_icache_refill_ctrl;

  logic         clk;
  logic         rst;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         cpu_ready;
  logic [31:0]  cpu_rdata;
  logic         flush;
  logic         busy;
  logic [8:0]   line_idx;
  logic [127:0] line_rdata;
  logic         line_we;
  logic [127:0] line_wdata;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [31:0]  mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which lines are resident and under which tag.
  bit   [511:0] m_valid;
  logic [18:0]  m_tag [512];

  // External data array and memory responder.
  logic [127:0] darr [512];
  assign line_rdata = darr[line_idx];
  assign mem_rdata  = mem_addr - 32'hA00;
  always @(posedge clk) if (line_we) darr[line_idx] <= line_wdata;

  icache_refill_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .flush      (flush),
    .busy       (busy),
    .line_idx   (line_idx),
    .line_rdata (line_rdata),
    .line_we    (line_we),
    .line_wdata (line_wdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One fetch. smode: 0 = memory always ready, 1 = stall beat sbeat for 3
  // cycles, 2 = random stalls. flush_cyc > 0 pulses flush in that cycle of
  // the transaction; flush_req raises flush together with cpu_req.
  task automatic fetch(input logic [31:0] addr, input int smode, input int sbeat,
                       input int flush_cyc, input bit flush_req);
    logic [18:0]  tag;
    logic [8:0]   idx;
    logic [31:0]  base;
    logic [31:0]  exp_data;
    logic [127:0] exp_line;
    bit           exp_hit;
    int           off, lat_exp, ready_c, we_c, beats, stalls, stall_run, we_cnt;
    tag      = addr[31:13];
    idx      = addr[12:4];
    base     = {addr[31:4], 4'b0000};
    exp_data = {addr[31:2], 2'b00} - 32'hA00;
    for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = base + 32'(4*k) - 32'hA00;
    off = flush_req ? 2 : 0;
    if (flush_req) m_valid = '0;
    exp_hit = m_valid[idx] && (m_tag[idx] == tag);
    ready_c = -1; we_c = -1; beats = 0; stalls = 0; stall_run = 0; we_cnt = 0;

    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_addr = addr;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      flush = (c == 0 && flush_req) || (flush_cyc > 0 && c == flush_cyc);
      case (smode)
        1:       mem_ready = !(beats == sbeat && stall_run < 3);
        2:       mem_ready = ($urandom_range(0, 3) != 0);
        default: mem_ready = 1'b1;
      endcase
      @(negedge clk);
      check("busy", busy, (c != 0) && (c != off));
      if (mem_req) begin
        check("mem_addr", mem_addr, base + 32'(4*beats));
        if (mem_ready) beats++;
        else begin stalls++; stall_run++; end
      end
      if (line_we) begin
        we_cnt++;
        we_c = c;
        check("line_idx", line_idx, idx);
        check("line_wdata", line_wdata, exp_line);
      end
      if (cpu_ready) begin
        ready_c = c;
        break;
      end
    end
    lat_exp = off + (exp_hit ? 1 : 7 + stalls);
    check("latency", ready_c, lat_exp);
    if (ready_c >= 0) check("cpu_rdata", cpu_rdata, exp_data);
    check("beats", beats, exp_hit ? 0 : 4);
    check("line_we_count", we_cnt, exp_hit ? 0 : 1);
    if (!exp_hit) check("line_we_cycle", we_c, lat_exp - 1);

    if (!exp_hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    if (flush_cyc > 0) m_valid = '0;

    @(posedge clk); #1;
    cpu_req   = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_after", busy, 1'b0);
  endtask

  // Reset while the second refill beat is on the bus; expects 0xA04 to miss.
  task automatic reset_mid_refill();
    int we_seen;
    we_seen = 0;
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_addr  = 32'h0000_0A04;
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 3) rst = 1'b1;
      @(negedge clk);
      if (line_we) we_seen++;
    end
    check("rst_beat1_req", mem_req, 1'b1);
    check("rst_beat1_addr", mem_addr, 32'h0000_0A04);
    @(posedge clk); #1;
    rst     = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    repeat (6) begin
      @(negedge clk);
      if (line_we) we_seen++;
    end
    check("rst_no_line_we", we_seen, 0);
    m_valid = '0;
  endtask

  initial begin
    logic [31:0] a;
    int          r, fc;
    bit          fr;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    flush     = 1'b0;
    mem_ready = 1'b1;
    m_valid   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_line_we", line_we, 1'b0);
    check("rst_line_wdata", line_wdata, 128'h0);
    check("rst_line_idx", line_idx, 9'h0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss, hit on the same line, conflict eviction and re-miss.
    fetch(32'h0000_0A04, 0, 0, 0, 0);
    fetch(32'h0000_0A08, 0, 0, 0, 0);
    fetch(32'h0000_2A04, 0, 0, 0, 0);
    fetch(32'h0000_0A04, 0, 0, 0, 0);
    // Stall beat 2 for three cycles while refilling line 0xA00.
    fetch(32'h0000_2A04, 0, 0, 0, 0);
    fetch(32'h0000_0A04, 1, 2, 0, 0);
    // Flush during REFILL, then a previously resident line misses.
    fetch(32'h0000_0A14, 0, 0, 3, 0);
    fetch(32'h0000_0A04, 0, 0, 0, 0);
    // Flush in the WRITE cycle invalidates the line just filled.
    fetch(32'h0000_2A04, 0, 0, 6, 0);
    fetch(32'h0000_2A04, 0, 0, 0, 0);
    // Flush together with a request in IDLE.
    fetch(32'h0000_2A08, 0, 0, 0, 0);
    fetch(32'h0000_2A08, 0, 0, 0, 1);
    // Reset in the middle of a burst, then restart from beat 0.
    reset_mid_refill();
    fetch(32'h0000_0A04, 0, 0, 0, 0);

    // Randomized fetches over a few tags and indices to mix hits and conflicts.
    for (int n = 0; n < 60; n++) begin
      a[31:13] = 19'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       a[12:4] = 9'h0A0;
        1:       a[12:4] = 9'h0A1;
        default: a[12:4] = 9'($urandom);
      endcase
      a[3:0] = 4'($urandom);
      r  = $urandom_range(0, 9);
      fr = (r == 0);
      fc = (r == 1) ? 1 : 0;
      if (r == 2) fc = (m_valid[a[12:4]] && m_tag[a[12:4]] == a[31:13]) ? 1 : 6;
      fetch(a, $urandom_range(0, 2), $urandom_range(0, 3), fc, fr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Direct-mapped instruction-cache controller; sits between the CPU-side fetch port and the memory-side AHB master.
- Owns the tag and valid arrays and sequences lookup, 4-beat line refill and data-array write.
- Returns the requested 32-bit word to the CPU.
- The data array is external: one 128-bit line, combinational read by index, synchronous write.

Parameters:
- CACHE_LINE, 128, line width in bits. Fixed at 4 words; other values are unsupported.
- CACHE_SIZE, 8192, cache capacity in bytes. NLINES = CACHE_SIZE*8/CACHE_LINE = 512, so IDX_W = 9.
- Address split: tag = addr[31:13], index = addr[12:4], offset = addr[3:2]. addr[1:0] is ignored.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  fetch request; held until cpu_ready
- cpu_addr  in  32  fetch byte address; stable while cpu_req is high
- cpu_ready  out  1  one-cycle pulse; cpu_rdata is valid in that cycle
- cpu_rdata  out  32  fetched word
- flush  in  1  invalidate all lines (level, sampled per cycle)
- busy  out  1  FSM not in IDLE
- line_idx  out  IDX_W  data-array index (read and write)
- line_rdata  in  128  data-array line at line_idx (combinational)
- line_we  out  1  data-array write enable, one cycle
- line_wdata  out  128  refilled line; word k at bits [32k+31:32k]
- mem_req  out  1  beat request to the memory side
- mem_addr  out  32  beat address {tag, index, beat[1:0], 2'b00}
- mem_ready  in  1  beat accepted; mem_rdata valid in the same cycle
- mem_rdata  in  32  beat data

Behaviour:
- Reset values: cpu_ready=0, cpu_rdata=0, mem_req=0, mem_addr=0, line_we=0, line_wdata=0, line_idx=0, busy=0.
- Reset also clears all valid bits, forces IDLE and zeroes the beat counter and the pending-flush flag.
- Reset mid-refill abandons the burst. mem_req is low in the cycle after the reset edge, and no line or tag is written.

FSM states: IDLE, COMPARE, REFILL, WRITE, RESPOND, FLUSH.
- IDLE
  - flush=1 -> FLUSH. This has priority over cpu_req; the request is not accepted and stays pending.
  - else cpu_req=1 -> latch cpu_addr, go to COMPARE.
- COMPARE
  - line_idx = latched index.
  - Hit = valid[idx] && tag_ram[idx]==tag.
  - Hit -> cpu_ready=1, cpu_rdata = line_rdata word[offset], then IDLE.
  - Miss -> REFILL with beat=0.
- REFILL
  - mem_req=1, mem_addr = {tag, idx, beat, 2'b00}.
  - Beats run in order 0..3; there is no critical-word-first.
  - When mem_req && mem_ready: store mem_rdata into buffer word[beat], then increment beat.
  - Beat 3 accepted -> WRITE.
  - mem_ready low stalls indefinitely with mem_addr held.
- WRITE
  - line_we=1, line_wdata=buffer, line_idx=idx.
  - tag_ram[idx]=tag, valid[idx]=1.
  - Then RESPOND.
- RESPOND
  - cpu_ready=1, cpu_rdata = buffer word[offset].
  - Then IDLE. The requester drops or changes cpu_req in the cycle after cpu_ready.
- FLUSH
  - All valid bits cleared in one cycle, pending flag cleared, then IDLE.
- Flush asserted outside IDLE sets a pending flag. The current transaction completes unchanged, then FLUSH is entered from IDLE before any new request.
- A flush in the same cycle as WRITE takes effect after WRITE, so the newly filled line is also invalidated.

Latency (measured from the cycle cpu_req is accepted in IDLE):
- Hit: cpu_ready in cycle +1; back-to-back hits complete every 2 cycles.
- Miss with mem_ready always high: mem_req in cycles +2..+5, line_we in +6, cpu_ready in +7.
- busy = (state != IDLE).

Test Plan:
- After reset, cpu_addr=0x0000_0A04 -> miss.
  - Memory model returns data = addr - 0xA00.
  - mem_addr sequence is 0xA00, 0xA04, 0xA08, 0xA0C; line_we at idx 0x0A0.
  - cpu_ready with cpu_rdata=0x4 at cycle +7.
- Follow-up cpu_addr=0x0000_0A08 -> hit, cpu_ready at +1 with rdata=0x8, no mem_req.
- Conflict: cpu_addr=0x0000_2A04 (same idx 0x0A0, tag 1) -> full refill with rdata=0x2004.
  - A subsequent 0xA04 misses again and returns 0x4.
- Refill with mem_ready low for 3 cycles on beat 2 -> mem_addr holds 0xA08 throughout; final line words are 0, 4, 8, C.
- Flush pulse during REFILL -> transaction completes normally, then FLUSH.
  - The next access to 0xA04 misses.
  - flush together with cpu_req in IDLE -> request served only after FLUSH.
- rst asserted on the 2nd beat of a refill -> mem_req=0 the next cycle, no line_we.
  - A re-request of 0xA04 misses and restarts at beat 0 (mem_addr 0xA00).
